// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   state_e : responder FSM state encoding (2 bits)
//   op_e    : latched access kind
//   LAT_W   : wait-state counter width (LATENCY range 0..15)
package mem_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/data_mem_array.sv
// Synchronous single-port RAM, 2^DEPTH_LOG2 words of 32 bits, no reset.
//   clk : clock
//   we  : write enable, commits wd to mem[idx] on the rising edge
//   idx : word index
//   wd  : write data
//   rd  : registered read data (old contents on a same-edge write)
module data_mem_array #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wd,
  output logic [31:0]           rd
);

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wd;
    end
    rd_q <= mem[idx];
  end

  assign rd = rd_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. A request seen in IDLE
// is latched, waits LATENCY+1 cycles in WAIT, performs the access on the last
// WAIT edge and reports completion with a one-cycle ready pulse in DONE.
//   clk, rst            : clock, asynchronous active-high reset
//   req_read, req_write : MEM-stage load / store request
//   addr, wdata         : byte address and store data
//   rdata               : load data, valid with ready, held until next read
//   ready, err          : completion pulse and its error flag
//   stall               : pipeline hold, (req_read|req_write) & ~ready
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam logic [LAT_W-1:0] LatInit = LAT_W'(LATENCY);

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        cnt_q, cnt_d;
  op_e                     op_q, op_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    err_n_q, err_n_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    ram_we;
  logic [31:0]             ram_rd;

  // Address bits above the memory depth wrap and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  data_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk(clk),
    .we (ram_we),
    .idx(idx_q),
    .wd (wdata_q),
    .rd (ram_rd)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      err_n_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_n_q <= err_n_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_n_d = err_n_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_read | req_write) begin
          state_d = S_WAIT;
          cnt_d   = LatInit;
          // Read+write together is serviced as a write and flagged.
          op_d    = req_write ? OP_WRITE : OP_READ;
          idx_d   = addr[DEPTH_LOG2+1:2];
          wdata_d = wdata;
          err_n_d = (addr[1:0] != 2'b00) | (req_read & req_write);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // Hold the read result so rdata stays valid after ready drops.
        if (op_q == OP_READ) begin
          rdata_d = ram_rd;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    // Writes commit only on the final WAIT edge; an async reset before that
    // edge leaves state IDLE and the write is dropped.
    ram_we = (state_q == S_WAIT) && (cnt_q == '0) && (op_q == OP_WRITE);
    ready  = (state_q == S_DONE);
    err    = ready & err_n_q;
    stall  = (req_read | req_write) & ~ready;
    rdata  = (ready && (op_q == OP_READ)) ? ram_rd : rdata_q;
  end

endmodule
